// File: rtl/pll_lock_reset_ctrl.sv
// pll_lock_reset_ctrl: PLL powerdown/lock sequencer that qualifies lock, retries on timeout or loss,
// and produces a glitch-free fabric reset and ready flag.
module pll_lock_reset_ctrl #(
  parameter int PD_HOLD_CYCLES      = 64,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int CNT_W               = 17,
  parameter int LOSS_CNT_W          = 8
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  ENABLE,
  input  logic                  PLL_LOCK,
  input  logic                  CLEAR_STATUS,
  output logic                  PLL_POWERDOWN_N,
  output logic                  FABRIC_RESET_N,
  output logic                  READY,
  output logic                  LOCK_FAIL,
  output logic [LOSS_CNT_W-1:0] LOSS_COUNT,
  output logic [2:0]            STATE
);
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PWRDN     = 3'd1,
    WAIT_LOCK = 3'd2,
    STABLE    = 3'd3,
    RUN       = 3'd4
  } state_e;
  localparam logic [CNT_W-1:0] PD_LAST = CNT_W'(PD_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ST_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [LOSS_CNT_W-1:0] loss_q, loss_d;
  logic                  sync_q, lock_s_q;
  logic                  pdn_q, pdn_d, run_q, run_d, fail_q, fail_d;
  logic                  timeout, lost;
  always_comb begin
    state_d = state_q;
    timeout = 1'b0;
    lost    = 1'b0;
    case (state_q)
      IDLE:      state_d = PWRDN;
      PWRDN:     if (cnt_q == PD_LAST) state_d = WAIT_LOCK;
      WAIT_LOCK: begin
        if (lock_s_q) state_d = STABLE;
        else if (cnt_q == TO_LAST) begin
          timeout = 1'b1;
          state_d = PWRDN;
        end
      end
      STABLE:    state_d = !lock_s_q ? WAIT_LOCK : (cnt_q == ST_LAST) ? RUN : STABLE;
      RUN:       begin
        lost    = !lock_s_q;
        state_d = lost ? PWRDN : RUN;
      end
      default:   state_d = IDLE;
    endcase
    // Disable overrides everything and is neither a loss nor a timeout
    if (!ENABLE) begin
      state_d = IDLE;
      timeout = 1'b0;
      lost    = 1'b0;
    end
    cnt_d  = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
    fail_d = timeout || (fail_q && !CLEAR_STATUS);
    loss_d = lost ? (CLEAR_STATUS ? LOSS_CNT_W'(1) : (&loss_q) ? loss_q : loss_q + LOSS_CNT_W'(1))
                  : (CLEAR_STATUS ? '0 : loss_q);
    pdn_d  = (state_d == WAIT_LOCK) || (state_d == STABLE) || (state_d == RUN);
    run_d  = state_d == RUN;
  end
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      loss_q   <= '0;
      sync_q   <= 1'b0;
      lock_s_q <= 1'b0;
      pdn_q    <= 1'b0;
      run_q    <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      loss_q   <= loss_d;
      sync_q   <= PLL_LOCK;
      lock_s_q <= sync_q;
      pdn_q    <= pdn_d;
      run_q    <= run_d;
      fail_q   <= fail_d;
    end
  end
  assign PLL_POWERDOWN_N = pdn_q;
  assign FABRIC_RESET_N  = run_q;
  assign READY           = run_q;
  assign LOCK_FAIL       = fail_q;
  assign LOSS_COUNT      = loss_q;
  assign STATE           = state_q;
endmodule

// File: tb/tb_pll_lock_reset_ctrl.sv
// tb_pll_lock_reset_ctrl: directed and randomized checks of the PLL sequencer against a
// countdown-based behavioural model of the lock/retry rules.
module tb_pll_lock_reset_ctrl;
  localparam int PD = 4;
  localparam int TO = 32;
  localparam int ST = 8;
  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       ENABLE = 1'b1;
  logic       PLL_LOCK = 1'b1;
  logic       CLEAR_STATUS = 1'b0;
  logic       PLL_POWERDOWN_N, FABRIC_RESET_N, READY, LOCK_FAIL;
  logic [7:0] LOSS_COUNT;
  logic [2:0] STATE;
  int total = 0;
  int bad = 0;
  pll_lock_reset_ctrl #(
    .PD_HOLD_CYCLES(PD), .LOCK_TIMEOUT_CYCLES(TO), .LOCK_STABLE_CYCLES(ST),
    .CNT_W(17), .LOSS_CNT_W(8)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .ENABLE(ENABLE), .PLL_LOCK(PLL_LOCK),
    .CLEAR_STATUS(CLEAR_STATUS), .PLL_POWERDOWN_N(PLL_POWERDOWN_N),
    .FABRIC_RESET_N(FABRIC_RESET_N), .READY(READY), .LOCK_FAIL(LOCK_FAIL),
    .LOSS_COUNT(LOSS_COUNT), .STATE(STATE)
  );
  always #5 CLK = ~CLK;
  typedef struct {
    int st;
    int left;
    bit fail;
    int loss;
    bit s1;
    bit s2;
  } model_t;
  model_t m = '{default: 0};
  // Phases hold for a number of remaining cycles; lock is seen two samples late.
  function automatic model_t step(model_t c, bit en, bit lk, bit clr);
    model_t n = c;
    bit tmo = 0;
    bit lost = 0;
    n.s1 = lk;
    n.s2 = c.s1;
    n.left = c.left - 1;
    if (!en) n.st = 0;
    else if (c.st == 0) begin n.st = 1; n.left = PD; end
    else if (c.st == 1) begin
      if (c.left == 1) begin n.st = 2; n.left = TO; end
    end else if (c.st == 2) begin
      if (c.s2) begin n.st = 3; n.left = ST; end
      else if (c.left == 1) begin tmo = 1; n.st = 1; n.left = PD; end
    end else if (c.st == 3) begin
      if (!c.s2) begin n.st = 2; n.left = TO; end
      else if (c.left == 1) n.st = 4;
    end else if (!c.s2) begin lost = 1; n.st = 1; n.left = PD; end
    n.fail = tmo || (c.fail && !clr);
    n.loss = lost ? (clr ? 1 : (c.loss >= 255 ? 255 : c.loss + 1)) : (clr ? 0 : c.loss);
    return n;
  endfunction
  always @(posedge CLK or negedge RESET_N)
    if (!RESET_N) m <= '{default: 0};
    else m <= step(m, ENABLE, PLL_LOCK, CLEAR_STATUS);
  function automatic logic [14:0] exp_vec();
    return {3'(m.st), (m.st >= 2 && m.st <= 4), m.st == 4, m.st == 4, m.fail, 8'(m.loss)};
  endfunction
  wire [14:0] dut_vec = {STATE, PLL_POWERDOWN_N, FABRIC_RESET_N, READY, LOCK_FAIL, LOSS_COUNT};
  always @(negedge CLK)
    assert (!(FABRIC_RESET_N && !PLL_POWERDOWN_N))
      else $error("FAIL fabric_reset_vs_powerdown: FABRIC_RESET_N=1 while PLL_POWERDOWN_N=0");
  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask
  task automatic wait_state(input logic [2:0] s, input int lim, output bit ok);
    int i = 0;
    while (STATE !== s && i < lim) begin
      @(negedge CLK);
      i++;
    end
    ok = STATE === s;
  endtask
  task automatic test_reset();
    tick(2);
    total++;
    if (dut_vec !== 15'd0) begin
      bad++;
      $display("FAIL reset_values: got %b want %b", dut_vec, 15'd0);
    end
  endtask
  task automatic test_powerup();
    int n1 = 0, n2 = 0, n3 = 0, pdl = 0, first_run = 0;
    RESET_N = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge CLK);
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++;
        $display("FAIL powerup_model c%0d: got %b want %b", i, dut_vec, exp_vec());
      end
      n1 += int'(STATE == 3'd1);
      n2 += int'(STATE == 3'd2);
      n3 += int'(STATE == 3'd3);
      pdl += int'(!PLL_POWERDOWN_N);
      if (STATE == 3'd4 && first_run == 0) begin
        first_run = i;
        total++;
        if ({FABRIC_RESET_N, READY, LOCK_FAIL, LOSS_COUNT} !== {3'b110, 8'd0}) begin
          bad++;
          $display("FAIL powerup_first_run: got %b want %b", {FABRIC_RESET_N, READY, LOCK_FAIL, LOSS_COUNT}, {3'b110, 8'd0});
        end
      end
    end
    total++;
    if ({n1, n2, n3, pdl, first_run} !== {32'd4, 32'd1, 32'd8, 32'd4, 32'd14}) begin
      bad++;
      $display("FAIL powerup_durations: pwrdn=%0d wait=%0d stable=%0d pdn_low=%0d first_run=%0d want 4 1 8 4 14", n1, n2, n3, pdl, first_run);
    end
  endtask
  task automatic test_lock_glitch();
    bit ok;
    bit saw_wait = 0;
    int run_len = 0, stable_len = 0;
    ENABLE = 1'b0;
    tick(1);
    ENABLE = 1'b1;
    wait_state(3'd3, 20, ok);
    tick(3);
    PLL_LOCK = 1'b0;
    tick(3);
    PLL_LOCK = 1'b1;
    for (int i = 0; i < 30; i++) begin
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++;
        $display("FAIL glitch_model c%0d: got %b want %b", i, dut_vec, exp_vec());
      end
      saw_wait |= STATE == 3'd2;
      run_len = (STATE == 3'd3) ? run_len + 1 : run_len;
      if (STATE == 3'd4 && stable_len == 0) stable_len = run_len;
      if (STATE != 3'd3 && STATE != 3'd4) run_len = 0;
      @(negedge CLK);
    end
    total++;
    if (!ok || !saw_wait || stable_len != ST || LOSS_COUNT !== 8'd0) begin
      bad++;
      $display("FAIL glitch: reached_stable=%0d saw_wait=%0d stable_len=%0d loss=%0d want 1 1 8 0", ok, saw_wait, stable_len, LOSS_COUNT);
    end
  endtask
  task automatic test_timeout();
    bit ok;
    int n2 = 0, n1 = 0, pdl = 0;
    ENABLE = 1'b0;
    PLL_LOCK = 1'b0;
    tick(3);
    ENABLE = 1'b1;
    wait_state(3'd2, 20, ok);
    total++;
    if (!ok || LOCK_FAIL !== 1'b0) begin
      bad++;
      $display("FAIL timeout_enter: reached=%0d lock_fail=%b want 1 0", ok, LOCK_FAIL);
    end
    // Clear lands on the timeout cycle itself; the timeout must win.
    while (STATE == 3'd2 && n2 < 100) begin
      n2++;
      CLEAR_STATUS = m.st == 2 && m.left == 1;
      @(negedge CLK);
    end
    CLEAR_STATUS = 1'b0;
    PLL_LOCK = 1'b1;
    total++;
    if (n2 != TO || STATE !== 3'd1 || LOCK_FAIL !== 1'b1) begin
      bad++;
      $display("FAIL timeout_len: wait=%0d state=%0d lock_fail=%b want 32 1 1", n2, STATE, LOCK_FAIL);
    end
    while (STATE == 3'd1 && n1 < 50) begin
      n1++;
      pdl += int'(!PLL_POWERDOWN_N);
      @(negedge CLK);
    end
    total++;
    if (n1 != PD || pdl != PD) begin
      bad++;
      $display("FAIL timeout_retry_pwrdn: pwrdn=%0d pdn_low=%0d want 4 4", n1, pdl);
    end
    wait_state(3'd4, 60, ok);
    total++;
    if (!ok || LOCK_FAIL !== 1'b1 || dut_vec !== exp_vec()) begin
      bad++;
      $display("FAIL timeout_sticky: run=%0d lock_fail=%b vec=%b want run 1 fail 1 vec %b", ok, LOCK_FAIL, dut_vec, exp_vec());
    end
    CLEAR_STATUS = 1'b1;
    tick(1);
    CLEAR_STATUS = 1'b0;
    total++;
    if (LOCK_FAIL !== 1'b0) begin
      bad++;
      $display("FAIL timeout_clear: lock_fail=%b want 0", LOCK_FAIL);
    end
  endtask
  task automatic test_loss_in_run();
    bit ok;
    PLL_LOCK = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      @(negedge CLK);
      total++;
      if (FABRIC_RESET_N !== (e < 3) || READY !== (e < 3)) begin
        bad++;
        $display("FAIL loss_edge%0d: fabric_reset_n=%b ready=%b want %b", e, FABRIC_RESET_N, READY, e < 3);
      end
    end
    total++;
    if (STATE !== 3'd1 || LOSS_COUNT !== 8'd1) begin
      bad++;
      $display("FAIL loss_first: state=%0d loss=%0d want 1 1", STATE, LOSS_COUNT);
    end
    for (int i = 0; i < 300; i++) begin
      PLL_LOCK = 1'b1;
      wait_state(3'd4, 60, ok);
      if (!ok) begin
        total++;
        bad++;
        $display("FAIL loss_relock: iteration %0d never reached RUN, state=%0d", i, STATE);
        break;
      end
      PLL_LOCK = 1'b0;
      tick(3);
      if (i == 98) begin
        total++;
        if (LOSS_COUNT !== 8'd100) begin
          bad++;
          $display("FAIL loss_count100: got %0d want 100", LOSS_COUNT);
        end
      end
    end
    total++;
    if (LOSS_COUNT !== 8'd255 || dut_vec !== exp_vec()) begin
      bad++;
      $display("FAIL loss_saturate: loss=%0d want 255 (vec %b model %b)", LOSS_COUNT, dut_vec, exp_vec());
    end
    PLL_LOCK = 1'b1;
    wait_state(3'd4, 60, ok);
    PLL_LOCK = 1'b0;
    tick(2);
    CLEAR_STATUS = 1'b1;
    tick(1);
    CLEAR_STATUS = 1'b0;
    total++;
    if (!ok || STATE !== 3'd1 || LOSS_COUNT !== 8'd1) begin
      bad++;
      $display("FAIL loss_clear_coincident: run=%0d state=%0d loss=%0d want 1 1 1", ok, STATE, LOSS_COUNT);
    end
  endtask
  task automatic test_control();
    bit ok;
    PLL_LOCK = 1'b1;
    wait_state(3'd4, 60, ok);
    ENABLE = 1'b0;
    tick(1);
    total++;
    if (!ok || dut_vec !== {3'd0, 4'b0000, 8'd1}) begin
      bad++;
      $display("FAIL enable_off: run=%0d got %b want %b", ok, dut_vec, {3'd0, 4'b0000, 8'd1});
    end
    ENABLE = 1'b1;
    wait_state(3'd3, 30, ok);
    tick(2);
    #2 RESET_N = 1'b0;
    #1;
    total++;
    if (!ok || dut_vec !== 15'd0) begin
      bad++;
      $display("FAIL async_reset: stable=%0d got %b want %b", ok, dut_vec, 15'd0);
    end
    @(negedge CLK);
    RESET_N = 1'b1;
  endtask
  task automatic test_lock_high_retry();
    bit ok;
    int pdl = 0, first_run = 0;
    wait_state(3'd4, 60, ok);
    ENABLE = 1'b0;
    tick(1);
    ENABLE = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge CLK);
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++;
        $display("FAIL retry_model c%0d: got %b want %b", i, dut_vec, exp_vec());
      end
      pdl += int'(!PLL_POWERDOWN_N);
      if (STATE == 3'd4 && first_run == 0) first_run = i;
    end
    total++;
    if (!ok || pdl != PD || first_run != 14) begin
      bad++;
      $display("FAIL retry_lock_high: run=%0d pdn_low=%0d first_run=%0d want 1 4 14", ok, pdl, first_run);
    end
  endtask
  task automatic test_random();
    int seg = 0;
    for (int i = 0; i < 4000; i++) begin
      if (seg == 0) begin
        PLL_LOCK = $urandom_range(0, 2) != 0;
        seg = PLL_LOCK ? $urandom_range(1, 40) : ($urandom_range(0, 3) == 0 ? $urandom_range(30, 70) : $urandom_range(1, 6));
      end
      seg--;
      ENABLE = $urandom_range(0, 199) != 0;
      CLEAR_STATUS = $urandom_range(0, 29) == 0;
      @(negedge CLK);
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++;
        $display("FAIL random c%0d: got %b want %b", i, dut_vec, exp_vec());
      end
    end
    ENABLE = 1'b1;
    CLEAR_STATUS = 1'b0;
  endtask
  initial begin
    test_reset();
    test_powerup();
    test_lock_glitch();
    test_timeout();
    test_loss_in_run();
    test_control();
    test_lock_high_retry();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
